// File: rtl/mdu_hilo.sv
// mdu_hilo: multi-cycle multiply/divide unit that owns the HI/LO pair.
//
// Ports:
//   clk, rst       clock; asynchronous active-high reset
//   alucontrol     8-bit operation code (same values the ALU decoder emits)
//   start          request valid for alucontrol/src_a/src_b this cycle
//   src_a, src_b   rs / rt operands
//   flush          synchronous cancel of any in-flight operation
//   busy           operation in flight; starts are ignored while high
//   done           one-cycle pulse when freshly committed HI/LO are visible
//   hi, lo         architectural HI/LO registers
//
// Handshake: a request is taken on a rising edge where start=1, busy=0,
// flush=0 and alucontrol is a recognised code. busy stays high from the
// cycle after that edge until the commit edge; done pulses in the cycle
// after the commit edge with busy already low, so the next request may be
// taken in the done cycle. MTHI/MTLO commit on the accept edge itself.
module mdu_hilo #(
    parameter int DIV_ITERS  = 32,
    parameter int MUL_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  alucontrol,
    input  logic        start,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    // Operation codes, matching the *_CONTROL values of the ALU decoder.
    localparam logic [7:0] MULT_CONTROL  = 8'h30;
    localparam logic [7:0] MULTU_CONTROL = 8'h31;
    localparam logic [7:0] MADD_CONTROL  = 8'h32;
    localparam logic [7:0] MADDU_CONTROL = 8'h33;
    localparam logic [7:0] MSUB_CONTROL  = 8'h34;
    localparam logic [7:0] MSUBU_CONTROL = 8'h35;
    localparam logic [7:0] DIV_CONTROL   = 8'h36;
    localparam logic [7:0] DIVU_CONTROL  = 8'h37;
    localparam logic [7:0] MTHI_CONTROL  = 8'h38;
    localparam logic [7:0] MTLO_CONTROL  = 8'h39;

    // The accept edge counts as the first multiply stage.
    localparam logic [4:0] MUL_LAST = 5'(MUL_STAGES - 2);
    localparam logic [4:0] DIV_LAST = 5'(DIV_ITERS - 1);

    localparam logic [1:0] ACC_SET = 2'd0;
    localparam logic [1:0] ACC_ADD = 2'd1;
    localparam logic [1:0] ACC_SUB = 2'd2;

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

    state_t      state;
    logic [4:0]  cnt;
    logic [31:0] opa;       // multiplicand, or dividend / quotient shift register
    logic [31:0] opb;       // multiplier, or divisor magnitude
    logic [31:0] rem;
    logic [31:0] raw_a;     // unmodified dividend for the divide-by-zero result
    logic        mul_signed;
    logic [1:0]  acc_mode;
    logic        qsign;
    logic        rsign;
    logic        div_zero;

    // Request decode
    logic        op_legal;
    logic        op_mul;
    logic        op_div;
    logic        op_signed;
    logic [1:0]  op_acc;
    logic        accept;

    always_comb begin
        op_legal  = 1'b0;
        op_mul    = 1'b0;
        op_div    = 1'b0;
        op_signed = 1'b0;
        op_acc    = ACC_SET;
        case (alucontrol)
            MULT_CONTROL:  begin op_legal = 1'b1; op_mul = 1'b1; op_signed = 1'b1; end
            MULTU_CONTROL: begin op_legal = 1'b1; op_mul = 1'b1; end
            MADD_CONTROL:  begin op_legal = 1'b1; op_mul = 1'b1; op_signed = 1'b1; op_acc = ACC_ADD; end
            MADDU_CONTROL: begin op_legal = 1'b1; op_mul = 1'b1; op_acc = ACC_ADD; end
            MSUB_CONTROL:  begin op_legal = 1'b1; op_mul = 1'b1; op_signed = 1'b1; op_acc = ACC_SUB; end
            MSUBU_CONTROL: begin op_legal = 1'b1; op_mul = 1'b1; op_acc = ACC_SUB; end
            DIV_CONTROL:   begin op_legal = 1'b1; op_div = 1'b1; op_signed = 1'b1; end
            DIVU_CONTROL:  begin op_legal = 1'b1; op_div = 1'b1; end
            MTHI_CONTROL:  op_legal = 1'b1;
            MTLO_CONTROL:  op_legal = 1'b1;
            default:       op_legal = 1'b0;
        endcase
    end

    assign accept = start && !flush && (state == IDLE) && op_legal;
    assign busy   = (state != IDLE);

    // Operand magnitudes for signed division
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    assign abs_a = (op_signed && src_a[31]) ? (32'd0 - src_a) : src_a;
    assign abs_b = (op_signed && src_b[31]) ? (32'd0 - src_b) : src_b;

    // Multiply: extend to 64 bits so one unsigned multiply covers both forms
    // modulo 2^64; accumulation uses HI/LO as they stand at the commit edge.
    logic [63:0] ext_a;
    logic [63:0] ext_b;
    logic [63:0] product;
    logic [63:0] mul_result;
    assign ext_a   = mul_signed ? {{32{opa[31]}}, opa} : {32'd0, opa};
    assign ext_b   = mul_signed ? {{32{opb[31]}}, opb} : {32'd0, opb};
    assign product = ext_a * ext_b;

    always_comb begin
        case (acc_mode)
            ACC_ADD: mul_result = {hi, lo} + product;
            ACC_SUB: mul_result = {hi, lo} - product;
            default: mul_result = product;
        endcase
    end

    // One restoring division step: shift the next dividend bit into the
    // partial remainder and subtract the divisor when it fits. The partial
    // remainder needs 33 bits before the compare; after subtraction it is
    // below the divisor, so 32 bits suffice.
    logic [32:0] rem_t;
    logic        rem_ge;
    logic [31:0] rem_sub;
    assign rem_t   = {rem, opa[31]};
    assign rem_ge  = (rem_t >= {1'b0, opb});
    assign rem_sub = rem_t[31:0] - opb;

    logic [31:0] quo_fix;
    logic [31:0] rem_fix;
    assign quo_fix = qsign ? (32'd0 - opa) : opa;
    assign rem_fix = rsign ? (32'd0 - rem) : rem;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 5'd0;
            opa        <= 32'd0;
            opb        <= 32'd0;
            rem        <= 32'd0;
            raw_a      <= 32'd0;
            mul_signed <= 1'b0;
            acc_mode   <= ACC_SET;
            qsign      <= 1'b0;
            rsign      <= 1'b0;
            div_zero   <= 1'b0;
            done       <= 1'b0;
            hi         <= 32'd0;
            lo         <= 32'd0;
        end else begin
            done <= 1'b0;
            if (flush) begin
                state <= IDLE;
                cnt   <= 5'd0;
            end else begin
                case (state)
                    IDLE: begin
                        if (accept) begin
                            cnt <= 5'd0;
                            if (alucontrol == MTHI_CONTROL) begin
                                hi   <= src_a;
                                done <= 1'b1;
                            end else if (alucontrol == MTLO_CONTROL) begin
                                lo   <= src_a;
                                done <= 1'b1;
                            end else if (op_mul) begin
                                opa        <= src_a;
                                opb        <= src_b;
                                mul_signed <= op_signed;
                                acc_mode   <= op_acc;
                                state      <= MUL;
                            end else if (op_div) begin
                                opa      <= abs_a;
                                opb      <= abs_b;
                                raw_a    <= src_a;
                                rem      <= 32'd0;
                                qsign    <= op_signed && (src_a[31] ^ src_b[31]);
                                rsign    <= op_signed && src_a[31];
                                div_zero <= (src_b == 32'd0);
                                state    <= DIV;
                            end
                        end
                    end
                    MUL: begin
                        if (cnt == MUL_LAST) begin
                            {hi, lo} <= mul_result;
                            done     <= 1'b1;
                            state    <= IDLE;
                        end else begin
                            cnt <= cnt + 5'd1;
                        end
                    end
                    DIV: begin
                        if (rem_ge) begin
                            rem <= rem_sub;
                            opa <= {opa[30:0], 1'b1};
                        end else begin
                            rem <= rem_t[31:0];
                            opa <= {opa[30:0], 1'b0};
                        end
                        if (cnt == DIV_LAST) begin
                            state <= FIX;
                        end else begin
                            cnt <= cnt + 5'd1;
                        end
                    end
                    FIX: begin
                        if (div_zero) begin
                            lo <= 32'hFFFF_FFFF;
                            hi <= raw_a;
                        end else begin
                            lo <= quo_fix;
                            hi <= rem_fix;
                        end
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mdu_hilo.sv
// tb_mdu_hilo: directed bench for mdu_hilo. The driver pushes the expected
// {hi,lo} for each committing op into exp_q; the monitor pops and compares
// whenever done is seen.
module tb_mdu_hilo;

    localparam logic [7:0] MULT  = 8'h30;
    localparam logic [7:0] MULTU = 8'h31;
    localparam logic [7:0] MADD  = 8'h32;
    localparam logic [7:0] MSUBU = 8'h35;
    localparam logic [7:0] DIV   = 8'h36;
    localparam logic [7:0] DIVU  = 8'h37;
    localparam logic [7:0] MTHI  = 8'h38;
    localparam logic [7:0] MTLO  = 8'h39;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  alucontrol = 8'h00;
    logic        start = 1'b0;
    logic [31:0] src_a = 32'd0;
    logic [31:0] src_b = 32'd0;
    logic        flush = 1'b0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    logic [63:0] exp_q[$];
    int total = 0;
    int bad   = 0;

    mdu_hilo dut (
        .clk        (clk),
        .rst        (rst),
        .alucontrol (alucontrol),
        .start      (start),
        .src_a      (src_a),
        .src_b      (src_b),
        .flush      (flush),
        .busy       (busy),
        .done       (done),
        .hi         (hi),
        .lo         (lo)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (!rst && done) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: hi=%h lo=%h with nothing expected", hi, lo);
            end else begin
                check("hilo", {hi, lo}, exp_q.pop_front());
            end
        end
    end

    // Waits for done with a cycle bound; checks the number of busy cycles
    // seen while waiting unless exp_busy is negative.
    task automatic wait_done(input int exp_busy);
        int n = 0;
        int busy_cnt = 0;
        while (!done && n < 100) begin
            if (busy) busy_cnt++;
            @(negedge clk);
            n++;
        end
        check("done_seen", {63'd0, done}, 64'd1);
        check("busy_in_done", {63'd0, busy}, 64'd0);
        if (exp_busy >= 0) check("busy_cycles", 64'(busy_cnt), 64'(exp_busy));
    endtask

    task automatic issue(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        alucontrol = op;
        src_a      = a;
        src_b      = b;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic do_op(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input int exp_busy);
        exp_q.push_back(exp);
        issue(op, a, b);
        wait_done(exp_busy);
    endtask

    task automatic expect_quiet(input string name, input int cycles);
        int dones = 0;
        for (int i = 0; i < cycles; i++) begin
            if (done) dones++;
            @(negedge clk);
        end
        check(name, 64'(dones), 64'd0);
    endtask

    initial begin
        // Reset
        repeat (2) @(negedge clk);
        check("reset_state", {busy, done, hi, lo}, 66'd0);
        rst = 1'b0;

        do_op(MULT,  32'hFFFF_FFFD, 32'd5,        {32'hFFFF_FFFF, 32'hFFFF_FFF1}, 1);
        do_op(DIVU,  32'd100,       32'd7,        {32'd2,         32'd14},        33);
        do_op(DIV,   32'hFFFF_FFF9, 32'd2,        {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33);
        do_op(MTLO,  32'h10,        32'd0,        {32'hFFFF_FFFF, 32'h10},        0);
        do_op(MTHI,  32'h0,         32'd0,        {32'h0,         32'h10},        0);
        do_op(MADD,  32'd2,         32'd3,        {32'h0,         32'h16},        1);
        do_op(MSUBU, 32'h1,         32'h17,       {32'hFFFF_FFFF, 32'hFFFF_FFFF}, 1);
        do_op(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {32'hFFFF_FFFE, 32'h0000_0001}, 1);
        do_op(DIVU,  32'd5,         32'd0,        {32'd5,         32'hFFFF_FFFF}, 33);
        do_op(DIV,   32'h8000_0000, 32'hFFFF_FFFF, {32'h0,        32'h8000_0000}, 33);

        // Unrecognised code is ignored
        issue(8'hFF, 32'd1, 32'd1);
        check("illegal_busy", {63'd0, busy}, 64'd0);
        expect_quiet("illegal_no_done", 4);

        // Flush mid-divide
        do_op(MTHI, 32'hAAAA, 32'd0, {32'hAAAA, 32'h8000_0000}, 0);
        do_op(MTLO, 32'h5555, 32'd0, {32'hAAAA, 32'h5555},      0);
        issue(DIVU, 32'd1000, 32'd3);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy", {63'd0, busy}, 64'd0);
        expect_quiet("flush_no_done", 40);
        check("flush_hilo", {hi, lo}, {32'hAAAA, 32'h5555});

        // Start while busy is ignored
        exp_q.push_back({32'd2, 32'd14});
        issue(DIVU, 32'd100, 32'd7);
        repeat (5) @(negedge clk);
        alucontrol = MTLO;
        src_a      = 32'h1234;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(-1);

        // Asynchronous reset mid-divide
        issue(DIVU, 32'd100, 32'd7);
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1 check("async_reset", {busy, done, hi, lo}, 66'd0);
        @(negedge clk);
        rst = 1'b0;
        do_op(MTHI, 32'h77, 32'd0, {32'h77, 32'h0}, 0);

        repeat (3) @(negedge clk);
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
